counter_nbit_modes: RTL and testbench
=====================================

Name: counter_nbit_modes

Overview:
Parametrised next-generation mode counter: WIDTH-bit up/down/step counter with parallel load, ripple-carry-out pulse and cascade input. Successor to the fixed 4-bit mode counter driven by the existing random driver/checker/scoreboard bench. It adds:
- configurable width and step;
- optional saturation instead of wrap;
- a cascade carry input so instances can be chained into wider counters.

Parameters:
WIDTH, 8, counter/data width in bits (>=2)
STEP, 3, increment used in mode 2'b10 (1 <= STEP < 2^WIDTH)
SATURATE, 0, 0 = modulo-2^WIDTH wrap; 1 = clamp at 0 / 2^WIDTH-1

Ports:
clk  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-high reset
enable  input  1  block enable; low = hold all state
cin  input  1  cascade carry-in; gates count modes only (tie 1 when unchained)
mode  input  2  00 up by 1, 01 down by 1, 10 up by STEP, 11 parallel load
D  input  WIDTH  parallel load value
Q  output  WIDTH  registered count
rco  output  1  registered one-cycle pulse on wrap/clamp event
load  output  1  registered one-cycle pulse: load performed this edge

Behaviour:
- One clock (clk); reset is synchronous and active-high. All outputs are registered; every update happens on a rising clk edge.
- Priority at each edge: reset > !enable > mode.
- reset=1: Q=0, rco=0, load=0. Reset held mid-count overrides any mode or enable value.
- enable=0: Q holds its value; rco=0, load=0 (pulses never stretch).
- mode=11 (load): Q<=D, load=1, rco=0. cin is ignored.
- Count modes (00/01/10), enable=1, cin=0: Q holds; rco=0, load=0.
- Count modes, enable=1, cin=1:
  - Sum computed at WIDTH+1 bits: up = Q+1, step = Q+STEP, down = Q-1 with borrow.
  - SATURATE=0: Q <= sum mod 2^WIDTH. rco=1 iff carry/borrow out (up past max, step crossing max, down past 0); else 0.
  - SATURATE=1: on overflow Q <= 2^WIDTH-1; on underflow Q <= 0; rco=1 on the edge the clamp occurs. Holding at the limit with further counts re-asserts rco each edge.
  - load=0.
- Mode and D changes take effect at the next edge. No pipeline; latency is 1 cycle from input to Q/rco/load.
- Cascade use: connect the lower stage's rco to the upper stage's cin. Both stages share enable and mode. The upper stage advances on the same edge as the lower stage's wrap only in registered-ripple form, i.e. one cycle late. This one-cycle skew is specified behaviour.
- No X propagation is allowed from an undriven D when mode!=11.

Test Plan:
- Reset: any inputs, reset=1 for 2 edges -> Q=0x00, rco=0, load=0. Then reset=0, mode=00, enable=1, cin=1 -> Q=0x01 after 1 edge.
- Up wrap (SATURATE=0): load D=0xFE, then mode=00 -> Q=0xFF (rco=0), then Q=0x00 with rco=1 for exactly one cycle, then Q=0x01 with rco=0.
- Step crossing: load D=0xFD, mode=10 (STEP=3) -> Q=0x00 with rco=1. Next edge Q=0x03, rco=0.
- Down borrow plus saturate instance (SATURATE=1): load D=0x01, mode=01 -> Q=0x00 (rco=1 on the clamp edge in the saturate instance only), then Q stays 0x00 with rco=1 each edge. The wrap instance instead reaches 0xFF with rco=1.
- Load and hold: mode=11, D=0xA5 -> Q=0xA5, load=1 for one cycle. Then enable=0 for 3 edges with mode=00 -> Q=0xA5, rco=0, load=0 throughout. A cin=0 count edge -> Q unchanged.
- Cascade and mid-run reset: two WIDTH=4 instances chained, count up from 0x0F (combined) -> low stage wraps to 0 with rco, high stage reads 1 one edge later. Asserting reset during a count sequence -> both stages read 0 on the next edge.

Source files
------------

// File: rtl/counter_nbit_modes_if.sv
// Control/data bundle for counter_nbit_modes: the master drives mode, enable and load data.
// The slave (the counter) returns the registered count and its event pulses.
interface counter_nbit_modes_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic             cin;
   logic [1:0]       mode;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             rco;
   logic             load;

   modport master (
      output enable, cin, mode, D,
      input  Q, rco, load
   );

   modport slave (
      input  enable, cin, mode, D,
      output Q, rco, load
   );
endinterface

// File: rtl/counter_nbit_modes.sv
// WIDTH-bit up/down/step counter with parallel load, wrap or saturate on overflow,
// registered ripple-carry-out pulse and a cascade carry-in that gates the count modes.
module counter_nbit_modes #(
   parameter int          WIDTH    = 8,
   parameter int unsigned STEP     = 3,
   parameter bit          SATURATE = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   counter_nbit_modes_if.slave   bus
);
   localparam logic [1:0]       MODE_UP   = 2'b00;
   localparam logic [1:0]       MODE_DOWN = 2'b01;
   localparam logic [1:0]       MODE_STEP = 2'b10;
   localparam logic [1:0]       MODE_LOAD = 2'b11;
   localparam logic [WIDTH:0]   ONE_EXT   = (WIDTH+1)'(1);
   localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] Q_MAX     = {WIDTH{1'b1}};

   logic [WIDTH-1:0] q_q, q_d;
   logic             rco_q, rco_d;
   logic             load_q, load_d;
   logic [WIDTH:0]   sum;

   // Extra top bit of sum is the carry (up/step) or borrow (down) out.
   always_comb begin
      sum = {1'b0, q_q} + ONE_EXT;
      case (bus.mode)
         MODE_DOWN: sum = {1'b0, q_q} - ONE_EXT;
         MODE_STEP: sum = {1'b0, q_q} + STEP_EXT;
         default:   sum = {1'b0, q_q} + ONE_EXT;
      endcase
   end

   always_comb begin
      q_d    = q_q;
      rco_d  = 1'b0;
      load_d = 1'b0;
      if (bus.enable) begin
         if (bus.mode == MODE_LOAD) begin
            q_d    = bus.D;
            load_d = 1'b1;
         end else if (bus.cin) begin
            rco_d = sum[WIDTH];
            if (SATURATE && sum[WIDTH]) begin
               q_d = (bus.mode == MODE_DOWN) ? '0 : Q_MAX;
            end else begin
               q_d = sum[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q    <= '0;
         rco_q  <= 1'b0;
         load_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         rco_q  <= rco_d;
         load_q <= load_d;
      end
   end

   assign bus.Q    = q_q;
   assign bus.rco  = rco_q;
   assign bus.load = load_q;

   // MODE_UP is the default arm above; referenced here so every encoding is named.
   logic unused_mode_up;
   assign unused_mode_up = (bus.mode == MODE_UP);
endmodule

// File: tb/tb_counter_nbit_modes.sv
// Directed bench: wrap and saturate 8-bit instances driven in lockstep, plus two
// chained 4-bit stages for the cascade check.
module tb_counter_nbit_modes;
   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       cin;
   logic [1:0] mode;
   logic [7:0] d;
   logic [3:0] d_lo, d_hi;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   counter_nbit_modes_if #(.WIDTH(8)) bus_w ();
   counter_nbit_modes_if #(.WIDTH(8)) bus_s ();
   counter_nbit_modes_if #(.WIDTH(4)) bus_lo ();
   counter_nbit_modes_if #(.WIDTH(4)) bus_hi ();

   assign bus_w.enable  = enable;
   assign bus_w.cin     = cin;
   assign bus_w.mode    = mode;
   assign bus_w.D       = d;
   assign bus_s.enable  = enable;
   assign bus_s.cin     = cin;
   assign bus_s.mode    = mode;
   assign bus_s.D       = d;
   assign bus_lo.enable = enable;
   assign bus_lo.cin    = cin;
   assign bus_lo.mode   = mode;
   assign bus_lo.D      = d_lo;
   assign bus_hi.enable = enable;
   assign bus_hi.cin    = bus_lo.rco;
   assign bus_hi.mode   = mode;
   assign bus_hi.D      = d_hi;

   counter_nbit_modes #(.WIDTH(8), .STEP(3), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .bus(bus_w));
   counter_nbit_modes #(.WIDTH(8), .STEP(3), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .reset(reset), .bus(bus_s));
   counter_nbit_modes #(.WIDTH(4), .STEP(1), .SATURATE(1'b0)) dut_lo (
      .clk(clk), .reset(reset), .bus(bus_lo));
   counter_nbit_modes #(.WIDTH(4), .STEP(1), .SATURATE(1'b0)) dut_hi (
      .clk(clk), .reset(reset), .bus(bus_hi));

   task automatic tick();
      @(posedge clk);
      #1;
      $display("t=%0t rst=%b en=%b cin=%b mode=%b | Qw=%h rw=%b lw=%b | Qs=%h rs=%b | hi:lo=%h:%h rlo=%b",
               $time, reset, enable, cin, mode, bus_w.Q, bus_w.rco, bus_w.load,
               bus_s.Q, bus_s.rco, bus_hi.Q, bus_lo.Q, bus_lo.rco);
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; cin = 1'b1; mode = 2'b11; d = 8'h5A;
      d_lo = 4'h7; d_hi = 4'h3;
      tick();
      tick();
      checks++;
      if (bus_w.Q !== 8'h00 || bus_w.rco !== 1'b0 || bus_w.load !== 1'b0) begin
         errors++;
         $display("FAIL reset_wrap Q=%h rco=%b load=%b expected Q=00 rco=0 load=0", bus_w.Q, bus_w.rco, bus_w.load);
      end
      checks++;
      if (bus_s.Q !== 8'h00 || bus_s.rco !== 1'b0 || bus_s.load !== 1'b0) begin
         errors++;
         $display("FAIL reset_sat Q=%h rco=%b load=%b expected Q=00 rco=0 load=0", bus_s.Q, bus_s.rco, bus_s.load);
      end
      reset = 1'b0; mode = 2'b00;
      tick();
      checks++;
      if (bus_w.Q !== 8'h01 || bus_w.rco !== 1'b0 || bus_w.load !== 1'b0) begin
         errors++;
         $display("FAIL first_count Q=%h rco=%b load=%b expected Q=01 rco=0 load=0", bus_w.Q, bus_w.rco, bus_w.load);
      end
   endtask

   task automatic test_up_wrap();
      mode = 2'b11; d = 8'hFE;
      tick();
      checks++;
      if (bus_w.Q !== 8'hFE || bus_w.load !== 1'b1 || bus_w.rco !== 1'b0) begin
         errors++;
         $display("FAIL load_fe Q=%h load=%b rco=%b expected Q=fe load=1 rco=0", bus_w.Q, bus_w.load, bus_w.rco);
      end
      mode = 2'b00;
      tick();
      checks++;
      if (bus_w.Q !== 8'hFF || bus_w.rco !== 1'b0 || bus_w.load !== 1'b0) begin
         errors++;
         $display("FAIL up_to_ff Q=%h rco=%b load=%b expected Q=ff rco=0 load=0", bus_w.Q, bus_w.rco, bus_w.load);
      end
      tick();
      checks++;
      if (bus_w.Q !== 8'h00 || bus_w.rco !== 1'b1) begin
         errors++;
         $display("FAIL up_wrap Q=%h rco=%b expected Q=00 rco=1", bus_w.Q, bus_w.rco);
      end
      checks++;
      if (bus_s.Q !== 8'hFF || bus_s.rco !== 1'b1) begin
         errors++;
         $display("FAIL up_clamp Q=%h rco=%b expected Q=ff rco=1", bus_s.Q, bus_s.rco);
      end
      tick();
      checks++;
      if (bus_w.Q !== 8'h01 || bus_w.rco !== 1'b0) begin
         errors++;
         $display("FAIL after_wrap Q=%h rco=%b expected Q=01 rco=0", bus_w.Q, bus_w.rco);
      end
   endtask

   task automatic test_step();
      mode = 2'b11; d = 8'hFD;
      tick();
      mode = 2'b10;
      tick();
      checks++;
      if (bus_w.Q !== 8'h00 || bus_w.rco !== 1'b1) begin
         errors++;
         $display("FAIL step_cross Q=%h rco=%b expected Q=00 rco=1", bus_w.Q, bus_w.rco);
      end
      checks++;
      if (bus_s.Q !== 8'hFF || bus_s.rco !== 1'b1) begin
         errors++;
         $display("FAIL step_clamp Q=%h rco=%b expected Q=ff rco=1", bus_s.Q, bus_s.rco);
      end
      tick();
      checks++;
      if (bus_w.Q !== 8'h03 || bus_w.rco !== 1'b0) begin
         errors++;
         $display("FAIL step_next Q=%h rco=%b expected Q=03 rco=0", bus_w.Q, bus_w.rco);
      end
      checks++;
      if (bus_s.Q !== 8'hFF || bus_s.rco !== 1'b1) begin
         errors++;
         $display("FAIL step_hold_max Q=%h rco=%b expected Q=ff rco=1", bus_s.Q, bus_s.rco);
      end
   endtask

   task automatic test_down();
      mode = 2'b11; d = 8'h01;
      tick();
      mode = 2'b01;
      tick();
      checks++;
      if (bus_w.Q !== 8'h00 || bus_w.rco !== 1'b0 || bus_s.Q !== 8'h00 || bus_s.rco !== 1'b0) begin
         errors++;
         $display("FAIL down_to_zero Qw=%h rw=%b Qs=%h rs=%b expected 00 0 00 0", bus_w.Q, bus_w.rco, bus_s.Q, bus_s.rco);
      end
      tick();
      checks++;
      if (bus_w.Q !== 8'hFF || bus_w.rco !== 1'b1) begin
         errors++;
         $display("FAIL down_borrow Q=%h rco=%b expected Q=ff rco=1", bus_w.Q, bus_w.rco);
      end
      checks++;
      if (bus_s.Q !== 8'h00 || bus_s.rco !== 1'b1) begin
         errors++;
         $display("FAIL down_clamp Q=%h rco=%b expected Q=00 rco=1", bus_s.Q, bus_s.rco);
      end
      tick();
      checks++;
      if (bus_w.Q !== 8'hFE || bus_w.rco !== 1'b0 || bus_s.Q !== 8'h00 || bus_s.rco !== 1'b1) begin
         errors++;
         $display("FAIL down_hold Qw=%h rw=%b Qs=%h rs=%b expected fe 0 00 1", bus_w.Q, bus_w.rco, bus_s.Q, bus_s.rco);
      end
   endtask

   task automatic test_load_hold();
      mode = 2'b11; d = 8'hA5;
      tick();
      checks++;
      if (bus_w.Q !== 8'hA5 || bus_w.load !== 1'b1 || bus_w.rco !== 1'b0) begin
         errors++;
         $display("FAIL load_a5 Q=%h load=%b rco=%b expected Q=a5 load=1 rco=0", bus_w.Q, bus_w.load, bus_w.rco);
      end
      enable = 1'b0; mode = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus_w.Q !== 8'hA5 || bus_w.load !== 1'b0 || bus_w.rco !== 1'b0) begin
            errors++;
            $display("FAIL disabled_hold%0d Q=%h load=%b rco=%b expected Q=a5 load=0 rco=0", i, bus_w.Q, bus_w.load, bus_w.rco);
         end
      end
      enable = 1'b1; cin = 1'b0;
      tick();
      checks++;
      if (bus_w.Q !== 8'hA5 || bus_w.load !== 1'b0 || bus_w.rco !== 1'b0) begin
         errors++;
         $display("FAIL cin_low_hold Q=%h load=%b rco=%b expected Q=a5 load=0 rco=0", bus_w.Q, bus_w.load, bus_w.rco);
      end
      cin = 1'b1; d = 8'hxx;
      tick();
      checks++;
      if (bus_w.Q !== 8'hA6 || bus_w.rco !== 1'b0) begin
         errors++;
         $display("FAIL count_undriven_d Q=%h rco=%b expected Q=a6 rco=0", bus_w.Q, bus_w.rco);
      end
   endtask

   task automatic test_cascade();
      mode = 2'b11; d = 8'h00; d_lo = 4'hF; d_hi = 4'h0;
      tick();
      checks++;
      if (bus_hi.Q !== 4'h0 || bus_lo.Q !== 4'hF) begin
         errors++;
         $display("FAIL casc_load hi:lo=%h:%h expected 0:f", bus_hi.Q, bus_lo.Q);
      end
      mode = 2'b00;
      tick();
      checks++;
      if (bus_hi.Q !== 4'h0 || bus_lo.Q !== 4'h0 || bus_lo.rco !== 1'b1) begin
         errors++;
         $display("FAIL casc_lo_wrap hi:lo=%h:%h rlo=%b expected 0:0 rlo=1", bus_hi.Q, bus_lo.Q, bus_lo.rco);
      end
      tick();
      checks++;
      if (bus_hi.Q !== 4'h1 || bus_lo.Q !== 4'h1 || bus_lo.rco !== 1'b0) begin
         errors++;
         $display("FAIL casc_hi_ripple hi:lo=%h:%h rlo=%b expected 1:1 rlo=0", bus_hi.Q, bus_lo.Q, bus_lo.rco);
      end
      tick();
      checks++;
      if (bus_hi.Q !== 4'h1 || bus_lo.Q !== 4'h2) begin
         errors++;
         $display("FAIL casc_continue hi:lo=%h:%h expected 1:2", bus_hi.Q, bus_lo.Q);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (bus_hi.Q !== 4'h0 || bus_lo.Q !== 4'h0 || bus_lo.rco !== 1'b0 || bus_w.Q !== 8'h00) begin
         errors++;
         $display("FAIL mid_run_reset hi:lo=%h:%h rlo=%b Qw=%h expected 0:0 rlo=0 Qw=00", bus_hi.Q, bus_lo.Q, bus_lo.rco, bus_w.Q);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus_lo.Q !== 4'h1 || bus_hi.Q !== 4'h0) begin
         errors++;
         $display("FAIL after_reset_count hi:lo=%h:%h expected 0:1", bus_hi.Q, bus_lo.Q);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; cin = 1'b1; mode = 2'b00;
      d = 8'h00; d_lo = 4'h0; d_hi = 4'h0;
      #2;
      test_reset();
      test_up_wrap();
      test_step();
      test_down();
      test_load_hold();
      test_cascade();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
